// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer:
// FSM states, instruction classes, opcode/ImmSrc/ResultSrc/ALU codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE,
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_LUI,
    CL_AUIPC
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_UPPER = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Registered control bundle driven during EXEC/MEM.
  typedef struct packed {
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       branch;
    logic       alu_en;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] result_src;
  } ctrl_t;

  // Only beq/bne are supported among branches.
  function automatic cls_e op_class(input logic [6:0] op,
                                    input logic [2:0] f3);
    cls_e c;
    unique case (1'b1)
      (op == OP_R):      c = CL_R;
      (op == OP_I):      c = CL_I;
      (op == OP_LOAD):   c = CL_LOAD;
      (op == OP_STORE):  c = CL_STORE;
      (op == OP_BRANCH): c = (f3[2:1] == 2'b00) ? CL_BRANCH : CL_NONE;
      (op == OP_JAL):    c = CL_JAL;
      (op == OP_LUI):    c = CL_LUI;
      (op == OP_AUIPC):  c = CL_AUIPC;
      default:           c = CL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// mc_alu_decoder: maps (class, funct3, funct7[5]) to ALUControl.
// Ports: cls, funct3, funct7b5 in; alu_ctrl out (combinational).
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  cls_e       cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (cls)
      CL_BRANCH: alu_ctrl = ALU_SUB;
      CL_R, CL_I: begin
        unique case (funct3)
          // SUB only exists in R form; addi ignores funct7[5]
          3'b000: alu_ctrl = (cls == CL_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/TRAP).
// Ports: clk, reset(async low), Instr, Zero, imem/dmem handshakes, datapath
// enables/selects, sticky illegal/bus_err traps, instret counter.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e           state;
  cls_e             cls_q;
  logic [2:0]       f3_q;
  logic             f7_q;
  ctrl_t            ctrl_q;
  logic [15:0]      wait_cnt;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             illegal_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] instret_q;

  cls_e       cls_d;
  ctrl_t      exec_ctrl;
  logic [3:0] alu_ctrl;
  logic       fetch_done;
  logic       mem_done;
  logic       wait_expired;
  logic       is_mem;
  logic       unused_instr;

  assign cls_d        = op_class(Instr[6:0], Instr[14:12]);
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign is_mem       = (cls_q == CL_LOAD) || (cls_q == CL_STORE);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  mc_alu_decoder u_alu_dec (
    .cls      (cls_q),
    .funct3   (f3_q),
    .funct7b5 (f7_q),
    .alu_ctrl (alu_ctrl)
  );

  // EXEC-cycle controls, registered on the DECODE->EXEC edge.
  always_comb begin
    exec_ctrl = '0;
    exec_ctrl.alu_en = (cls_d != CL_NONE);
    unique case (cls_d)
      CL_R: begin
        exec_ctrl.reg_write = 1'b1;
        exec_ctrl.pc_write  = 1'b1;
      end
      CL_I: begin
        exec_ctrl.reg_write = 1'b1;
        exec_ctrl.pc_write  = 1'b1;
        exec_ctrl.alu_src   = 1'b1;
        exec_ctrl.imm_src   = IMM_I;
      end
      CL_LOAD: begin
        exec_ctrl.alu_src    = 1'b1;
        exec_ctrl.imm_src    = IMM_I;
        exec_ctrl.result_src = RES_MEM;
      end
      CL_STORE: begin
        exec_ctrl.alu_src = 1'b1;
        exec_ctrl.imm_src = IMM_S;
      end
      CL_BRANCH: begin
        exec_ctrl.pc_write = 1'b1;
        exec_ctrl.branch   = 1'b1;
        exec_ctrl.imm_src  = IMM_B;
      end
      CL_JAL: begin
        exec_ctrl.reg_write  = 1'b1;
        exec_ctrl.pc_write   = 1'b1;
        exec_ctrl.pc_src     = 1'b1;
        exec_ctrl.imm_src    = IMM_J;
        exec_ctrl.result_src = RES_PC4;
      end
      CL_LUI, CL_AUIPC: begin
        exec_ctrl.reg_write  = 1'b1;
        exec_ctrl.pc_write   = 1'b1;
        exec_ctrl.result_src = RES_UPPER;
      end
      default: exec_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cls_q      <= CL_NONE;
      f3_q       <= '0;
      f7_q       <= 1'b0;
      ctrl_q     <= '0;
      wait_cnt   <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
          wait_cnt   <= '0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state      <= S_DECODE;
            imem_req_q <= 1'b0;
          end else if (wait_expired) begin
            state      <= S_TRAP;
            imem_req_q <= 1'b0;
            bus_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          cls_q <= cls_d;
          f3_q  <= Instr[14:12];
          f7_q  <= Instr[30];
          if (cls_d == CL_NONE) begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state  <= S_EXEC;
            ctrl_q <= exec_ctrl;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            // address controls in ctrl_q stay put through MEM
            state      <= S_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == CL_STORE);
            wait_cnt   <= '0;
          end else begin
            state      <= S_FETCH;
            ctrl_q     <= '0;
            imem_req_q <= 1'b1;
            wait_cnt   <= '0;
            instret_q  <= instret_q + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state      <= S_FETCH;
            ctrl_q     <= '0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            imem_req_q <= 1'b1;
            wait_cnt   <= '0;
            instret_q  <= instret_q + CNT_W'(1);
          end else if (wait_expired) begin
            state      <= S_TRAP;
            ctrl_q     <= '0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            bus_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Ready is only honoured while the matching request is up.
  assign fetch_done = imem_req_q & imem_ready;
  assign mem_done   = dmem_req_q & dmem_ready;

  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign IRWrite    = fetch_done;
  assign PCWrite    = ctrl_q.pc_write | mem_done;
  assign RegWrite   = ctrl_q.reg_write | (mem_done & ~dmem_we_q);
  assign PCSrc      = ctrl_q.pc_src | (ctrl_q.branch & (Zero ^ f3_q[0]));
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrc     = ctrl_q.alu_src;
  assign ImmSrc     = ctrl_q.imm_src;
  assign ALUControl = ctrl_q.alu_en ? alu_ctrl : ALU_ADD;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller.
// Driver pushes expected commits; a negedge monitor pops and compares.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        IRWrite, PCWrite, PCSrc, ALUSrc, RegWrite;
  logic [1:0]  ResultSrc, ImmSrc;
  logic [3:0]  ALUControl;
  logic        illegal, bus_err;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ResultSrc(ResultSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  typedef struct packed {
    logic       rw;
    logic       ps;
    logic [1:0] rs;
    logic [3:0] alu;
    logic       as;
    logic [1:0] is;
    logic       dr;
    logic       dw;
  } obs_t;

  typedef struct {
    obs_t v;
    obs_t m;
    int   cyc;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_cnt = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00502223;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BNE  = 32'h00001063;
  localparam logic [31:0] I_JALR = 32'h000080E7;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [17:0] outs();
    return {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCSrc,
            ResultSrc, ALUSrc, RegWrite, ImmSrc, ALUControl,
            illegal, bus_err};
  endfunction

  // Reference: what the commit cycle must look like for one instruction.
  function automatic exp_t model(logic [31:0] ins, logic z,
                                 int iw, int dw, int cnt);
    exp_t e;
    logic [3:0] tbl [8];
    logic [2:0] f3;
    logic       f7;
    bit         mem;
    tbl = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
    f3  = ins[14:12];
    f7  = ins[30];
    mem = 0;
    e.v = '0;
    e.m = '0;
    e.m.rw = 1; e.m.ps = 1; e.m.dr = 1; e.m.dw = 1;
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.v.rw = 1; e.m.rs = '1; e.m.alu = '1; e.m.as = 1;
        e.v.alu = tbl[f3];
        if (f3 == 3'd0 && f7 && ins[6:0] == 7'h33) e.v.alu = 4'h1;
        if (f3 == 3'd5 && f7) e.v.alu = 4'h9;
        if (ins[6:0] == 7'h13) begin
          e.v.as = 1; e.m.is = '1;
        end
      end
      7'h03: begin
        mem = 1; e.v.rw = 1; e.v.rs = 2'd1; e.v.as = 1; e.v.dr = 1;
        e.m.rs = '1; e.m.alu = '1; e.m.as = 1; e.m.is = '1;
      end
      7'h23: begin
        mem = 1; e.v.as = 1; e.v.is = 2'd1; e.v.dr = 1; e.v.dw = 1;
        e.m.alu = '1; e.m.as = 1; e.m.is = '1;
      end
      7'h63: begin
        e.v.ps = z ^ f3[0]; e.v.alu = 4'h1; e.v.is = 2'd2;
        e.m.alu = '1; e.m.as = 1; e.m.is = '1; e.m.rs = '1;
      end
      7'h6F: begin
        e.v.rw = 1; e.v.ps = 1; e.v.rs = 2'd2; e.v.is = 2'd3;
        e.m.rs = '1; e.m.is = '1;
      end
      default: begin
        e.v.rw = 1; e.v.rs = 2'd3; e.m.rs = '1;
      end
    endcase
    e.cyc = (iw + 1) + 2 + (mem ? dw + 1 : 0);
    e.cnt = cnt;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [8];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
    r = $urandom;
    k = $urandom_range(0, 7);
    r[6:0] = ops[k];
    if (k == 4) r[14:13] = 2'b00;
    return r;
  endfunction

  // Monitor: every PCWrite must match the oldest expected commit.
  int   mon_cyc = 0;
  bit   mon_busy = 0;
  exp_t me;
  obs_t mo;
  always @(negedge clk) begin
    if (!reset) begin
      mon_busy = 0;
      mon_cyc  = 0;
    end else begin
      if (imem_req && !mon_busy) begin
        mon_busy = 1;
        mon_cyc  = 0;
      end
      if (mon_busy) mon_cyc++;
      if (PCWrite) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 64'(PCWrite), 64'd0);
        end else begin
          me = sb.pop_front();
          mo = {RegWrite, PCSrc, ResultSrc, ALUControl, ALUSrc, ImmSrc,
                dmem_req, dmem_we};
          chk("commit_ctrl", 64'(mo & me.m), 64'(me.v & me.m));
          chk("commit_latency", 64'(mon_cyc), 64'(me.cyc));
          chk("commit_instret", 64'(instret), 64'(me.cnt));
        end
        mon_busy = 0;
      end
    end
  end

  task automatic fetch_phase(int w);
    int n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req) chk("imem_req_timeout", 64'(imem_req), 64'd1);
    repeat (w) begin
      imem_ready = 1'b0;
      dmem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    dmem_ready = 1'($urandom);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (!dmem_req && n < 50) begin
      dmem_ready = 1'($urandom);
      imem_ready = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    if (!dmem_req) chk("dmem_req_timeout", 64'(dmem_req), 64'd1);
  endtask

  task automatic mem_phase(int w);
    wait_dreq();
    repeat (w) begin
      dmem_ready = 1'b0;
      imem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
  endtask

  task automatic run_instr(logic [31:0] ins, logic z, int iw, int dw);
    exp_t e;
    e = model(ins, z, iw, dw, model_cnt);
    sb.push_back(e);
    model_cnt++;
    Instr = ins;
    Zero  = z;
    fetch_phase(iw);
    if (ins[6:0] == 7'h03 || ins[6:0] == 7'h23) begin
      mem_phase(dw);
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    sb.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    reset = 1'b0; Instr = '0; Zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    chk("reset_instret", 64'(instret), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("fetch_after_reset", 64'(imem_req), 64'd1);

    run_instr(I_ADD, 1'b0, 0, 0);
    run_instr(I_LW,  1'b0, 0, 3);
    run_instr(I_BEQ, 1'b1, 0, 0);
    run_instr(I_BNE, 1'b1, 0, 0);
    run_instr(I_SW,  1'b0, 1, 2);
    run_instr(I_ADD, 1'b0, 3, 0);
    for (int i = 0; i < 60; i++) begin
      run_instr(rand_instr(), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("instret_total", 64'(instret), 64'(model_cnt));
    chk("no_bus_err", 64'(bus_err), 64'd0);

    // jalr traps as illegal without committing or fetching again
    do_reset();
    run_instr(I_ADD, 1'b0, 0, 0);
    Instr = I_JALR;
    fetch_phase(0);
    @(posedge clk); #1;
    req_cycles = 0;
    repeat (8) begin
      if (imem_req) req_cycles++;
      @(posedge clk); #1;
    end
    chk("jalr_illegal", 64'(illegal), 64'd1);
    chk("jalr_no_fetch", 64'(req_cycles), 64'd0);
    chk("jalr_instret", 64'(instret), 64'd1);

    // fetch timeout after exactly 4 waiting cycles
    do_reset();
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("fetch_wait4_no_err", 64'({bus_err, imem_req}), 64'b01);
    @(posedge clk); #1;
    chk("fetch_timeout_err", 64'({bus_err, imem_req}), 64'b10);

    // data timeout
    do_reset();
    Instr = I_SW;
    fetch_phase(0);
    wait_dreq();
    repeat (3) @(posedge clk);
    #1;
    chk("mem_wait4_no_err", 64'({bus_err, dmem_req, dmem_we}), 64'b011);
    @(posedge clk); #1;
    chk("mem_timeout_err", 64'({bus_err, dmem_req, PCWrite}), 64'b100);

    // asynchronous reset in the middle of MEM
    do_reset();
    run_instr(I_ADD, 1'b0, 0, 0);
    Instr = I_LW;
    fetch_phase(0);
    wait_dreq();
    @(posedge clk); #2;
    chk("mem_req_before_reset", 64'(dmem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs()), 64'd0);
    chk("async_reset_instret", 64'(instret), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("idle_after_release", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    chk("fetch_resumes", 64'(imem_req), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control sequencer for the RV32I datapath (pcreg, reg_file, alu, resultmux, lauipcmux).
- Drives the datapath control inputs and the PC/instruction-register enables.
- Handshakes with instruction and data memories that take a variable number of cycles to respond.
- Each instruction passes through FETCH, DECODE, EXEC and, for loads/stores, MEM. PC and register file change only in a single commit cycle.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before bus-error trap; legal range 1..65535.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Instr  in  32  instruction from the IR; valid from DECODE onward
- Zero  in  1  ALU zero flag
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete; IR captures on IRWrite
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ready  in  1  data access complete; load data valid this cycle
- IRWrite  out  1  IR load enable
- PCWrite  out  1  PC register enable (commit)
- PCSrc  out  1  0 = PC+4, 1 = PC+imm
- ResultSrc  out  2  00 ALU, 01 mem, 10 PC+4, 11 lui/auipc
- ALUSrc  out  1  0 = rs2, 1 = imm
- RegWrite  out  1  register-file write enable (commit only)
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  4  ALU operation code
- illegal  out  1  sticky; unsupported instruction trapped
- bus_err  out  1  sticky; memory timeout trapped
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including instret, illegal and bus_err. The decode latch is cleared.
  - Reset mid-operation aborts immediately. No commit occurs and requests drop in the same cycle reset asserts.
- IDLE:
  - Entered only from reset. Goes to FETCH on the first clock edge after reset deasserts.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: IRWrite=1 that cycle, then go to DECODE.
  - When imem_ready=0: stay and increment the wait counter.
- DECODE (1 cycle):
  - Latch the class from Instr[6:0], plus funct3 and funct7[5].
  - Supported classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000/001 only), JAL 1101111, LUI 0110111, AUIPC 0010111.
  - Anything else, including JALR: set illegal and go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - Controls are driven from the latched class.
  - R/I-ALU/LUI/AUIPC/JAL: this is the commit cycle.
    - RegWrite=1 and PCWrite=1.
    - PCSrc=1 for JAL only.
    - ResultSrc: ALU classes 00, JAL 10, LUI/AUIPC 11.
  - BRANCH: this is the commit cycle.
    - PCWrite=1, ALUControl=SUB, ImmSrc=10.
    - PCSrc = Zero XOR funct3[0].
  - LOAD/STORE:
    - ALU computes address (ADD, ALUSrc=1, ImmSrc 00 for load, 01 for store).
    - Go to MEM.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - Address/control held stable until dmem_ready=1.
  - The dmem_ready cycle is the commit cycle: PCWrite=1, and for LOAD also RegWrite=1 with ResultSrc=01.
- After commit, return to FETCH and increment instret, wrapping modulo 2^CNT_W.
- ALU decode (R/I-ALU):
  - funct3: 000 ADD, or SUB when R and funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (by funct7[5]), 110 OR, 111 AND.
  - I-ALU with funct3 000 ignores funct7[5].
- Handshake:
  - req stays high until ready is sampled high.
  - ready while req=0 is ignored.
  - req drops the cycle after ready.
- Timeout:
  - The wait counter clears on entering FETCH/MEM.
  - If the counter reaches MEM_TIMEOUT with ready still 0, go to TRAP and set bus_err.
  - ready on the same cycle the limit is reached wins (normal completion).
- TRAP:
  - All enables and requests are 0. The block stays there until reset.
- Latency with zero-wait memories: ALU/branch/jump/lui/auipc 3 cycles, load/store 4 cycles.

Decomposition:
- Package mc_ctrl_pkg: state encoding (IDLE, FETCH, DECODE, EXEC, MEM, TRAP), opcode constants, and ImmSrc/ResultSrc codes.
- ALUControl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- One sub-module, mc_alu_decoder: combinational map of (class, funct3, funct7[5]) to ALUControl.

Test Plan:
- Reset then zero-wait add x3,x1,x2 (0x002081B3):
  - Expect imem_req in cycle 1, DECODE in cycle 2.
  - Cycle 3 shows RegWrite=1, PCWrite=1, ALUControl=0000, ResultSrc=00; instret=1.
- lw x5,8(x0) with dmem_ready delayed 3 cycles:
  - dmem_req=1 and dmem_we=0 are held for 4 cycles.
  - Commit has RegWrite=1 and ResultSrc=01; total 7 cycles.
- beq with Zero=1 then bne with Zero=1:
  - First gives PCSrc=1, second PCSrc=0.
  - Both give PCWrite=1, RegWrite=0, ALUControl=0001.
- jalr (0x000080E7):
  - illegal=1, TRAP entered, no PCWrite; instret unchanged; fetch stops.
- MEM_TIMEOUT=4 with imem_ready stuck at 0:
  - bus_err=1 after 4 wait cycles.
  - Repeat with ready asserted on the 4th cycle: no error.
- reset pulsed low during MEM with dmem_req=1:
  - Outputs go to 0 asynchronously, instret=0.
  - FETCH resumes one cycle after release.
